// File: rtl/pwf_meas.sv
// rtl/pwf_meas.sv - pulse width / period measurement with a first-word-fall-through result FIFO
`timescale 1ns/1ps
module pwf_meas #(
  parameter int CW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk11m,
  input  logic                     rst_n,
  input  logic                     i,
  input  logic                     meas_ready,
  input  logic                     clr_ovf,
  output logic                     meas_valid,
  output logic [CW-1:0]            meas_width,
  output logic [CW-1:0]            meas_period,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     ovf,
  output logic                     active
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  state_t         state_q, state_d;
  logic           i_dly_q;
  logic           armed_q;
  logic [CW-1:0]  wid_q, wid_d;
  logic [CW-1:0]  per_q, per_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           valid_q, valid_d;
  logic           ovf_q, ovf_d;
  logic           active_q, active_d;
  logic [CW-1:0]  mem_w [DEPTH];
  logic [CW-1:0]  mem_p [DEPTH];

  logic rise, fall, per_max, push_req, pop, push_ok, drop;

  // armed_q masks the first cycle after reset, when i_dly_q has not yet seen i
  assign rise    = i & ~i_dly_q & armed_q;
  assign fall    = ~i & i_dly_q;
  assign per_max = (per_q == {CW{1'b1}});

  always_ff @(posedge clk11m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (rise) state_d = S_HIGH;
      S_HIGH: begin
        if (per_max)   state_d = S_IDLE;
        else if (fall) state_d = S_LOW;
      end
      S_LOW: begin
        if (rise)         state_d = S_HIGH;
        else if (per_max) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counters report pre-reload values; a saturated period means the input is stuck
  always_comb begin
    push_req = (state_q == S_LOW) & rise;
    wid_d    = wid_q;
    per_d    = per_q;
    if (rise) begin
      wid_d = CW'(1);
      per_d = CW'(1);
    end else if (state_q != S_IDLE && !per_max) begin
      per_d = per_q + CW'(1);
      if (i) wid_d = wid_q + CW'(1);
    end
  end

  always_comb begin
    pop      = valid_q & meas_ready;
    push_ok  = push_req & ((level_q != FULL_LVL) | pop);
    drop     = push_req & ~push_ok;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push_ok && !pop)      level_d = level_q + LW'(1);
    else if (!push_ok && pop) level_d = level_q - LW'(1);
    valid_d  = (level_d != '0);
    ovf_d    = drop | (ovf_q & ~clr_ovf);
    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk11m or negedge rst_n) begin
    if (!rst_n) begin
      i_dly_q  <= 1'b0;
      armed_q  <= 1'b0;
      wid_q    <= '0;
      per_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      i_dly_q  <= i;
      armed_q  <= 1'b1;
      wid_q    <= wid_d;
      per_q    <= per_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      active_q <= active_d;
    end
  end

  always_ff @(posedge clk11m) begin
    if (push_ok) begin
      mem_w[wr_ptr_q] <= wid_q;
      mem_p[wr_ptr_q] <= per_q;
    end
  end

  assign meas_valid  = valid_q;
  assign meas_width  = valid_q ? mem_w[rd_ptr_q] : '0;
  assign meas_period = valid_q ? mem_p[rd_ptr_q] : '0;
  assign fifo_level  = level_q;
  assign ovf         = ovf_q;
  assign active      = active_q;

endmodule

// File: tb/tb_pwf_meas.sv
// tb/tb_pwf_meas.sv - directed self-checking bench for pwf_meas
`timescale 1ns/1ps
module tb_pwf_meas;

  localparam int CW    = 16;
  localparam int DEPTH = 4;

  logic          clk11m = 1'b0;
  logic          rst_n = 1'b0;
  logic          i = 1'b0;
  logic          meas_ready = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          meas_valid;
  logic [CW-1:0] meas_width;
  logic [CW-1:0] meas_period;
  logic [2:0]    fifo_level;
  logic          ovf;
  logic          active;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] cap[$];

  always #45 clk11m = ~clk11m;

  pwf_meas #(.CW(CW), .DEPTH(DEPTH)) dut (
    .clk11m      (clk11m),
    .rst_n       (rst_n),
    .i           (i),
    .meas_ready  (meas_ready),
    .clr_ovf     (clr_ovf),
    .meas_valid  (meas_valid),
    .meas_width  (meas_width),
    .meas_period (meas_period),
    .fifo_level  (fifo_level),
    .ovf         (ovf),
    .active      (active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Records the head whenever the coming edge will pop it
  task automatic step();
    if (meas_valid === 1'b1 && meas_ready === 1'b1) cap.push_back({meas_width, meas_period});
    @(posedge clk11m);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input int h, input int l);
    i = 1'b1;
    steps(h);
    i = 1'b0;
    steps(l);
  endtask

  task automatic do_reset();
    i = 1'b0;
    meas_ready = 1'b0;
    clr_ovf = 1'b0;
    rst_n = 1'b0;
    steps(2);
    rst_n = 1'b1;
    steps(2);
    cap.delete();
  endtask

  initial begin
    steps(2);
    chk("rst_valid", meas_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_active", active, 0);
    chk("rst_width", meas_width, 0);
    chk("rst_period", meas_period, 0);

    i = 1'b1;
    rst_n = 1'b1;
    step();
    chk("release_high_no_rise", active, 0);
    steps(3);
    chk("release_high_still_idle", active, 0);
    i = 1'b0;
    steps(3);

    meas_ready = 1'b1;
    pulse(20, 30);
    pulse(20, 30);
    chk("p20_first_cap", cap.size(), 1);
    i = 1'b1;
    step();
    chk("p20_valid", meas_valid, 1);
    chk("p20_width", meas_width, 20);
    chk("p20_period", meas_period, 50);
    chk("p20_level", fifo_level, 1);
    steps(19);
    i = 1'b0;
    steps(30);
    i = 1'b1;
    steps(2);
    chk("p20_count", cap.size(), 3);
    for (int k = 0; k < cap.size(); k++) chk("p20_rec", cap[k], {16'd20, 16'd50});

    do_reset();
    repeat (5) pulse(5, 5);
    chk("full_level", fifo_level, 4);
    chk("full_no_ovf", ovf, 0);
    i = 1'b1;
    step();
    chk("drop_ovf", ovf, 1);
    chk("drop_level", fifo_level, 4);
    steps(4);
    i = 1'b0;
    steps(5);
    meas_ready = 1'b1;
    steps(5);
    chk("drain_count", cap.size(), 4);
    for (int k = 0; k < cap.size(); k++) chk("drain_rec", cap[k], {16'd5, 16'd10});
    chk("drain_level", fifo_level, 0);
    chk("drain_valid", meas_valid, 0);
    meas_ready = 1'b0;

    chk("ovf_sticky", ovf, 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf_cleared", ovf, 0);
    step();
    chk("ovf_stays_clear", ovf, 0);

    do_reset();
    repeat (5) pulse(5, 5);
    chk("fullpop_pre_level", fifo_level, 4);
    meas_ready = 1'b1;
    i = 1'b1;
    step();
    meas_ready = 1'b0;
    chk("fullpop_level", fifo_level, 4);
    chk("fullpop_ovf", ovf, 0);
    chk("fullpop_valid", meas_valid, 1);
    steps(4);
    i = 1'b0;
    steps(5);
    i = 1'b1;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("drop_beats_clr", ovf, 1);
    chk("drop_clr_level", fifo_level, 4);

    do_reset();
    pulse(5, 5);
    pulse(5, 5);
    i = 1'b1;
    step();
    chk("midrst_pre_level", fifo_level, 2);
    chk("midrst_pre_active", active, 1);
    steps(2);
    rst_n = 1'b0;
    #1;
    chk("midrst_async_valid", meas_valid, 0);
    chk("midrst_async_level", fifo_level, 0);
    chk("midrst_async_active", active, 0);
    step();
    rst_n = 1'b1;
    chk("midrst_edge_level", fifo_level, 0);
    step();
    chk("midrst_release_idle", active, 0);

    do_reset();
    i = 1'b1;
    step();
    chk("stuck_start_active", active, 1);
    steps(65534);
    chk("stuck_not_early", active, 1);
    step();
    chk("stuck_timeout_active", active, 0);
    chk("stuck_timeout_level", fifo_level, 0);
    chk("stuck_timeout_valid", meas_valid, 0);
    steps(70000 - 65536);
    chk("stuck_stays_idle", active, 0);
    i = 1'b0;
    steps(5);
    pulse(7, 3);
    chk("resume_first_rise_no_push", fifo_level, 0);
    i = 1'b1;
    step();
    chk("resume_level", fifo_level, 1);
    chk("resume_valid", meas_valid, 1);
    chk("resume_width", meas_width, 7);
    chk("resume_period", meas_period, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwf_meas.md
PWF_MEAS -- requirements
Module: pwf_meas

Interface
REQ-001 SHALL have parameter CW, default 16, meaning width of the pulse-width and period counters and result fields.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of entries in the result FIFO (power of two, >= 2).
REQ-003 SHALL have port clk11m  input  1  meaning the single 11 MHz system clock; all logic rising-edge triggered.
REQ-004 SHALL have port rst_n  input  1  meaning the asynchronous, active-low reset.
REQ-005 SHALL have port i  input  1  meaning the filtered pulse from the upstream pulse-width filter, synchronous to clk11m, with no resynchronizer.
REQ-006 SHALL have port meas_ready  input  1  meaning the consumer accepts the head record.
REQ-007 SHALL have port clr_ovf  input  1  meaning a synchronous clear of the ovf flag.
REQ-008 SHALL have port meas_valid  output  1  meaning the FIFO is non-empty and the head record is presented.
REQ-009 SHALL have port meas_width  output  CW  meaning the high time of the head record, in clk11m cycles.
REQ-010 SHALL have port meas_period  output  CW  meaning the rising-to-rising time of the head record, in clk11m cycles.
REQ-011 SHALL have port fifo_level  output  clog2(DEPTH)+1  meaning the current FIFO occupancy.
REQ-012 SHALL have port ovf  output  1  meaning a sticky flag that a record was dropped on a full FIFO.
REQ-013 SHALL have port active  output  1  meaning the FSM is not in IDLE.

Function
REQ-014 SHALL register i into i_d each cycle; rise = i & !i_d, fall = !i & i_d.
REQ-015 SHALL implement FSM states IDLE, HIGH, LOW.
REQ-016 SHALL transition IDLE->HIGH on rise, with no push on that first rise.
REQ-017 SHALL transition HIGH->LOW on fall.
REQ-018 SHALL transition LOW->HIGH on rise and push one record on that transition.
REQ-019 SHALL set per_cnt to 1 and wid_cnt to 1 on any rise.
REQ-020 SHALL, in every other cycle of HIGH or LOW, increment per_cnt by 1.
REQ-021 SHALL increment wid_cnt only while i=1 and hold it while i=0.
REQ-022 SHALL, for a pulse high H cycles followed by low L cycles, push record {width=H, period=H+L} on the next rise, using counter values before the reload.
REQ-023 SHALL, when per_cnt would exceed 2^CW-1 in HIGH or LOW, return the FSM to IDLE with no push (stuck-signal timeout); the next rise restarts measurement as in REQ-016.
REQ-024 SHALL accept a push when fifo_level<DEPTH, or when fifo_level=DEPTH and a pop occurs in the same cycle.
REQ-025 SHALL, on any other push attempt while full, discard the record and set ovf=1.
REQ-026 SHALL clear ovf one cycle after clr_ovf=1; if a drop coincides with clr_ovf, ovf SHALL end at 1.
REQ-027 SHALL perform a pop when meas_valid=1 and meas_ready=1 in the same cycle.
REQ-028 SHALL hold meas_width and meas_period stable while meas_valid=1 and meas_ready=0.
REQ-029 SHALL assert meas_valid in the cycle after the pushing clock edge (push-to-valid latency 1 cycle).
REQ-030 SHALL make the FIFO first-word-fall-through, with read/write pointers wrapping modulo DEPTH.
REQ-031 SHALL increment fifo_level on push only, decrement it on pop only, and leave it unchanged on a simultaneous push and pop.
REQ-032 SHALL drive fifo_level, meas_valid, ovf and active from registers.

Reset
REQ-033 SHALL, on rst_n=0, immediately force FSM=IDLE, i_d=0, wid_cnt=0, per_cnt=0, FIFO pointers=0, fifo_level=0, meas_valid=0, ovf=0, active=0.
REQ-034 SHALL, while meas_valid=0, drive meas_width=0 and meas_period=0 after reset.
REQ-035 SHALL discard all stored records and any partial measurement when rst_n asserts mid-pulse.
REQ-036 SHALL, with i=1 at reset release, not treat that level as a rise, since i_d loads i on the first clock.

Verification
REQ-037 SHALL cover: i periodic, 20 high / 30 low, meas_ready=1 -> first record after second rise is width=20 period=50, and every later record is identical.
REQ-038 SHALL cover: meas_ready=0, six pulses of 5 high / 5 low -> fifo_level saturates at 4, ovf=1 after the fifth push, the first four records are preserved, and all records are width=5 period=10.
REQ-039 SHALL cover: FIFO full and a rise in the same cycle as meas_ready=1 -> the push is accepted, fifo_level stays 4, and ovf stays 0.
REQ-040 SHALL cover: i held high for 70000 cycles (CW=16) -> FSM returns to IDLE, active=0, and no record is pushed; the following pulses resume after a fresh first rise.
REQ-041 SHALL cover: rst_n pulsed low for 1 cycle mid-HIGH with 2 records queued -> meas_valid=0, fifo_level=0, and active=0 on the next edge.
REQ-042 SHALL cover: clr_ovf=1 for one cycle with ovf=1 and no concurrent drop -> ovf=0 on the next cycle.
